// File: rtl/multdiv_pkg.sv
// multdiv_pkg
//   Shared definitions for the multicycle MULT/DIV unit: FSM state encoding,
//   operation-select codes and the default datapath width / iteration count.
//   Imported by div_core and mult_div_unit.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // One Booth step or one quotient bit per clock, so the loop runs WIDTH times.
  localparam int ITER_COUNT = DEFAULT_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  // Two's complement magnitude; the most negative value maps to 2^(W-1),
  // which is still representable as an unsigned WIDTH-bit number.
  function automatic logic [DEFAULT_WIDTH-1:0] magnitude(input logic [DEFAULT_WIDTH-1:0] v);
    return v[DEFAULT_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// div_core
//   Unsigned restoring divider step engine. One quotient bit is produced per
//   step; after WIDTH steps quotient/remainder hold the magnitude result.
//   Ports:
//     Clk, reset      clock and synchronous active-high reset
//     load            capture dividend/divisor magnitudes, clear remainder
//     step            perform one shift/trial-subtract/restore step
//     dividend_mag    |dividend|
//     divisor_mag     |divisor|
//     remainder       running (final) remainder magnitude
//     quotient        running (final) quotient magnitude; dividend bits shift
//                     out of the top while quotient bits shift in at the bottom
module div_core
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend_mag,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient
);

  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Partial remainder shifted left with the next dividend bit, and the trial
  // subtraction. The extra top bit of trial acts as the borrow: set means the
  // divisor did not fit and the shifted value must be kept (restored).
  always_comb begin
    shifted = {remainder, quotient[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_r};
  end

  // Divide by zero is not special-cased: every trial succeeds, so the
  // quotient fills with ones and the dividend ends up in the remainder.
  always_ff @(posedge Clk) begin
    if (reset) begin
      remainder <= '0;
      quotient  <= '0;
      divisor_r <= '0;
    end else if (load) begin
      remainder <= '0;
      quotient  <= dividend_mag;
      divisor_r <= divisor_mag;
    end else if (step) begin
      if (trial[WIDTH]) begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end else begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multicycle signed multiply/divide unit owning the HI/LO registers.
//   MULT uses radix-2 Booth, DIV uses the div_core restoring engine on operand
//   magnitudes followed by a sign fix-up. Latency from the start edge to the
//   result edge is a fixed WIDTH+1 clocks.
//   Ports:
//     Clk, reset              clock (rising edge), synchronous active-high reset
//     start_mult, start_div   start requests, only looked at while idle
//                             (start_mult wins if both are high)
//     op_a, op_b              multiplicand/dividend, multiplier/divisor
//     busy                    operation in progress
//     done                    one-cycle pulse when HI/LO have been updated
//     div_zero                one-cycle pulse with done on divide by zero
//     hi, lo                  MULT: product high/low; DIV: remainder/quotient
//   Configuration macro: MULTDIV_DIVZERO_EN
//     defined   - divide by zero finishes after one clock, flags div_zero and
//                 leaves HI/LO untouched
//     undefined - div_zero is tied low and divide by zero runs the normal
//                 iteration, producing the natural restoring-divider result
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  op_t              op_sel;
  logic [CW-1:0]    counter;

  // Booth registers: acc is one bit wider than the operands so that adding or
  // subtracting a multiplicand of -2^(W-1) can never overflow.
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH:0]   booth_sum;

  logic             neg_quot;
  logic             neg_rem;
  logic             div_load;
  logic             div_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quot_mag;
  logic [WIDTH-1:0] rem_signed;
  logic [WIDTH-1:0] quot_signed;

`ifdef MULTDIV_DIVZERO_EN
  logic             dz_pending;
`endif

  // Booth recoding of the multiplier pair {q[0], q-1}: 01 adds, 10 subtracts.
  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
  end

  // Divider hookup. The core is loaded on any accepted divide start (even a
  // by-zero one that will be short-circuited) and steps while in DIV.
  always_comb begin
    a_mag    = magnitude(op_a);
    b_mag    = magnitude(op_b);
    div_load = (state == IDLE) && start_div && !start_mult;
    div_step = (state == DIV);
  end

  div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .Clk          (Clk),
    .reset        (reset),
    .load         (div_load),
    .step         (div_step),
    .dividend_mag (a_mag),
    .divisor_mag  (b_mag),
    .remainder    (rem_mag),
    .quotient     (quot_mag)
  );

  // Quotient truncates toward zero and is negated when the operand signs
  // differ; the remainder follows the dividend's sign. -2^(W-1) / -1 simply
  // wraps back to -2^(W-1).
  always_comb begin
    quot_signed = neg_quot ? (~quot_mag + 1'b1) : quot_mag;
    rem_signed  = neg_rem  ? (~rem_mag  + 1'b1) : rem_mag;
  end

  // Control FSM plus Booth datapath and HI/LO/status registers. Every
  // operation spends WIDTH steps in MULT or DIV and one clock in FINISH,
  // which writes the result and pulses done as it returns to IDLE, so a new
  // start can be taken in the very cycle done is visible.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= IDLE;
      op_sel   <= OP_MULT;
      counter  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      mcand    <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
      div_zero   <= 1'b0;
      dz_pending <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
      div_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          counter <= '0;
          if (start_mult) begin
            op_sel <= OP_MULT;
            acc    <= '0;
            mcand  <= {op_a[WIDTH-1], op_a};
            q      <= op_b;
            q_m1   <= 1'b0;
            busy   <= 1'b1;
            state  <= MULT;
`ifdef MULTDIV_DIVZERO_EN
            dz_pending <= 1'b0;
`endif
          end else if (start_div) begin
            op_sel   <= OP_DIV;
            neg_quot <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem  <= op_a[WIDTH-1];
            busy     <= 1'b1;
`ifdef MULTDIV_DIVZERO_EN
            if (op_b == '0) begin
              dz_pending <= 1'b1;
              state      <= FINISH;
            end else begin
              dz_pending <= 1'b0;
              state      <= DIV;
            end
`else
            state <= DIV;
`endif
          end
        end

        // One Booth step: add/subtract, then arithmetic right shift of the
        // concatenation {acc, q, q-1}.
        MULT: begin
          acc     <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q       <= {booth_sum[0], q[WIDTH-1:1]};
          q_m1    <= q[0];
          counter <= counter + 1'b1;
          if (counter == LAST_STEP) begin
            state <= FINISH;
          end
        end

        DIV: begin
          counter <= counter + 1'b1;
          if (counter == LAST_STEP) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
`ifdef MULTDIV_DIVZERO_EN
          if (dz_pending) begin
            div_zero <= 1'b1;
          end else if (op_sel == OP_MULT) begin
            hi <= acc[WIDTH-1:0];
            lo <= q;
          end else begin
            hi <= rem_signed;
            lo <= quot_signed;
          end
`else
          if (op_sel == OP_MULT) begin
            hi <= acc[WIDTH-1:0];
            lo <= q;
          end else begin
            hi <= rem_signed;
            lo <= quot_signed;
          end
`endif
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef MULTDIV_DIVZERO_EN
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: a table of signed MULT/DIV vectors
//   with hand-computed HI/LO, then hand-written sequences for divide by zero,
//   start arbitration, back-to-back starts and reset during an operation.
//   Honors MULTDIV_DIVZERO_EN for the divide-by-zero expectations.
module tb_mult_div_unit;

  logic        Clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  mult_div_unit #(
    .WIDTH(32)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        sm;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  // Compare one value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge after the start edge E0 (k=0). Returns k of the
  // negedge where done is first seen (-1 if never), counts cycles before
  // that where busy was low, and captures div_zero/busy alongside done.
  task automatic waitDone(output int lat, output int busy_errs, output logic dz, output logic busy_at_done);
    lat          = -1;
    busy_errs    = 0;
    dz           = 1'b0;
    busy_at_done = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge Clk);
      if (done) begin
        lat          = k;
        dz           = div_zero;
        busy_at_done = busy;
        break;
      end
      if (!busy) busy_errs++;
    end
  endtask

  // Present a start for one cycle, then wait for completion.
  task automatic applyStimulus(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busy_errs, output logic dz, output logic busy_at_done);
    @(negedge Clk);
    start_mult = sm;
    start_div  = sd;
    op_a       = a;
    op_b       = b;
    @(negedge Clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    waitDone(lat, busy_errs, dz, busy_at_done);
  endtask

  initial begin
    int   lat;
    int   busy_errs;
    logic dz;
    logic bad;
    int   done_count;
    int   done_at;

    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;

    vecs[0] = '{name:"mult 7*-3",         sm:1'b1, sd:1'b0, a:32'd7,          b:32'hFFFFFFFD, exp_hi:32'hFFFFFFFF, exp_lo:32'hFFFFFFEB};
    vecs[1] = '{name:"mult min*min",      sm:1'b1, sd:1'b0, a:32'h80000000,   b:32'h80000000, exp_hi:32'h40000000, exp_lo:32'h00000000};
    vecs[2] = '{name:"mult -1*1",         sm:1'b1, sd:1'b0, a:32'hFFFFFFFF,   b:32'd1,        exp_hi:32'hFFFFFFFF, exp_lo:32'hFFFFFFFF};
    vecs[3] = '{name:"mult max*max",      sm:1'b1, sd:1'b0, a:32'h7FFFFFFF,   b:32'h7FFFFFFF, exp_hi:32'h3FFFFFFF, exp_lo:32'h00000001};
    vecs[4] = '{name:"mult -4*-5",        sm:1'b1, sd:1'b0, a:32'hFFFFFFFC,   b:32'hFFFFFFFB, exp_hi:32'h00000000, exp_lo:32'h00000014};
    vecs[5] = '{name:"div -7/2",          sm:1'b0, sd:1'b1, a:32'hFFFFFFF9,   b:32'd2,        exp_hi:32'hFFFFFFFF, exp_lo:32'hFFFFFFFD};
    vecs[6] = '{name:"div 7/-2",          sm:1'b0, sd:1'b1, a:32'd7,          b:32'hFFFFFFFE, exp_hi:32'h00000001, exp_lo:32'hFFFFFFFD};
    vecs[7] = '{name:"div min/-1",        sm:1'b0, sd:1'b1, a:32'h80000000,   b:32'hFFFFFFFF, exp_hi:32'h00000000, exp_lo:32'h80000000};
    vecs[8] = '{name:"div -100/-7",       sm:1'b0, sd:1'b1, a:32'hFFFFFF9C,   b:32'hFFFFFFF9, exp_hi:32'hFFFFFFFE, exp_lo:32'h0000000E};
    vecs[9] = '{name:"both starts 6*7",   sm:1'b1, sd:1'b1, a:32'd6,          b:32'd7,        exp_hi:32'h00000000, exp_lo:32'h0000002A};

    // Reset state
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset div_zero", {31'd0, div_zero}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].sm, vecs[i].sd, vecs[i].a, vecs[i].b, lat, busy_errs, dz, bad);
      checkOutput({vecs[i].name, " latency"}, lat, 32'd33);
      checkOutput({vecs[i].name, " busy gaps"}, busy_errs, 32'd0);
      checkOutput({vecs[i].name, " busy at done"}, {31'd0, bad}, 32'd0);
      checkOutput({vecs[i].name, " div_zero"}, {31'd0, dz}, 32'd0);
      checkOutput({vecs[i].name, " hi"}, hi, vecs[i].exp_hi);
      checkOutput({vecs[i].name, " lo"}, lo, vecs[i].exp_lo);
      @(negedge Clk);
      checkOutput({vecs[i].name, " done width"}, {31'd0, done}, 32'd0);
    end

    // Divide by zero, with HI/LO preloaded by 2*3
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd3, lat, busy_errs, dz, bad);
    checkOutput("preload lo", lo, 32'd6);
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, lat, busy_errs, dz, bad);
`ifdef MULTDIV_DIVZERO_EN
    checkOutput("div0 latency", lat, 32'd1);
    checkOutput("div0 flag", {31'd0, dz}, 32'd1);
    checkOutput("div0 hi kept", hi, 32'd0);
    checkOutput("div0 lo kept", lo, 32'd6);
    @(negedge Clk);
    checkOutput("div0 flag width", {31'd0, div_zero}, 32'd0);
`else
    checkOutput("div0 latency", lat, 32'd33);
    checkOutput("div0 flag", {31'd0, dz}, 32'd0);
    checkOutput("div0 hi", hi, 32'd5);
    checkOutput("div0 lo", lo, 32'hFFFFFFFF);
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFB, 32'd0, lat, busy_errs, dz, bad);
    checkOutput("div0 neg hi", hi, 32'hFFFFFFFB);
    checkOutput("div0 neg lo", lo, 32'd1);
`endif

    // start_div pulsed at E10 of a multiply must be ignored
    @(negedge Clk);
    start_mult = 1'b1;
    op_a       = 32'd3;
    op_b       = 32'd5;
    @(negedge Clk);
    start_mult = 1'b0;
    done_count = 0;
    done_at    = -1;
    for (int k = 0; k <= 50; k++) begin
      if (k > 0) @(negedge Clk);
      if (k == 9) begin
        start_div = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd7;
      end
      if (k == 10) start_div = 1'b0;
      if (done) begin
        done_count++;
        if (done_at < 0) done_at = k;
      end
    end
    checkOutput("ignored start done count", done_count, 32'd1);
    checkOutput("ignored start latency", done_at, 32'd33);
    checkOutput("ignored start lo", lo, 32'd15);

    // Back-to-back: new start presented in the done cycle
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7, lat, busy_errs, dz, bad);
    checkOutput("b2b first lo", lo, 32'd14);
    checkOutput("b2b first hi", hi, 32'd2);
    start_mult = 1'b1;
    op_a       = 32'd9;
    op_b       = 32'd9;
    @(negedge Clk);
    start_mult = 1'b0;
    checkOutput("b2b busy after start", {31'd0, busy}, 32'd1);
    waitDone(lat, busy_errs, dz, bad);
    checkOutput("b2b second latency", lat, 32'd33);
    checkOutput("b2b second lo", lo, 32'd81);

    // Reset at E12 of a divide
    @(negedge Clk);
    start_div = 1'b1;
    op_a      = 32'd1000;
    op_b      = 32'd3;
    @(negedge Clk);
    start_div = 1'b0;
    repeat (11) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    done_count = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (done) done_count++;
    end
    checkOutput("abort no done", done_count, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, lat, busy_errs, dz, bad);
    checkOutput("post abort latency", lat, 32'd33);
    checkOutput("post abort lo", lo, 32'd12);
    checkOutput("post abort hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
